// File: rtl/comp_digit_serial.sv
// comp_digit_serial
// Sequential magnitude comparator. Operands A and B arrive as DIGIT-bit digit
// pairs, most significant digit first, over a valid/ready stream. When all
// digits of one comparison are in, the block reports A>B on g and A==B on e,
// with a one-cycle done pulse.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous active-high reset
//   start     in   1      begin a new comparison (only looked at in IDLE)
//   in_valid  in   1      a_d/b_d hold a valid digit pair
//   in_ready  out  1      a digit pair is accepted this cycle (RUN only)
//   a_d       in   DIGIT  current digit of A, MSB digit first
//   b_d       in   DIGIT  current digit of B, MSB digit first
//   g         out  1      registered result A>B, held until the next done
//   e         out  1      registered result A==B, held until the next done
//   done      out  1      one-cycle pulse: g/e were updated this cycle
//   busy      out  1      comparison in progress (RUN or DONE)
//
// Build option
//   EARLY_EXIT_EN : when defined, the first digit pair that differs decides the
//                   result and the block jumps straight to DONE. The producer
//                   must drop the rest of that operand when it sees done.
//                   When undefined, every comparison takes exactly NDIG digits.

module comp_digit_serial #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  output logic             g,
  output logic             e,
  output logic             done,
  output logic             busy
);

  // Guarded division so a bad DIGIT reaches the $error below rather than
  // tripping a divide-by-zero first.
  localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int NDIG  = WIDTH / DSAFE;
  localparam int NSAFE = (NDIG < 1) ? 1 : NDIG;
  localparam int CW    = $clog2(NSAFE) + 1;

  generate
    if (DIGIT < 1 || (WIDTH % DSAFE) != 0 || NDIG < 1) begin : g_bad_cfg
      $error("comp_digit_serial: WIDTH must be a positive multiple of DIGIT (DIGIT >= 1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic          gt;
  logic          eq;
  logic [CW-1:0] cnt;

  logic xfer;
  logic nxt_gt;
  logic nxt_eq;
  logic last_dig;
  logic finish;

  assign xfer     = in_valid & in_ready;
  assign last_dig = (cnt == CW'(NSAFE - 1));

  // Once a more significant digit differs the result is frozen; lower digits
  // only matter while everything above them has compared equal.
  always_comb begin
    nxt_gt = gt;
    nxt_eq = eq;
    if (eq) begin
      nxt_gt = (a_d > b_d);
      nxt_eq = (a_d == b_d);
    end
  end

`ifdef EARLY_EXIT_EN
  // eq is always 1 in RUN here (any mismatch leaves RUN), so nxt_eq==0 marks
  // the deciding digit.
  assign finish = last_dig | ~nxt_eq;
`else
  assign finish = last_dig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gt       <= 1'b0;
      eq       <= 1'b1;
      cnt      <= '0;
      g        <= 1'b0;
      e        <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_RUN;
            gt       <= 1'b0;
            eq       <= 1'b1;
            cnt      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        S_RUN: begin
          if (xfer) begin
            gt  <= nxt_gt;
            eq  <= nxt_eq;
            cnt <= cnt + CW'(1);
            if (finish) begin
              // Result is published on entry to DONE so that g/e are
              // already valid in the cycle done is high.
              state    <= S_DONE;
              in_ready <= 1'b0;
              g        <= nxt_gt;
              e        <= nxt_eq;
              done     <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_digit_serial.sv
module tb_comp_digit_serial;

  localparam int WIDTH = 6;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DIGIT-1:0] a_d = '0;
  logic [DIGIT-1:0] b_d = '0;
  logic             g, e, done, busy;

  int total = 0;
  int bad   = 0;

  bit exp_g_q[$];
  bit exp_e_q[$];

  comp_digit_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a_d(a_d), .b_d(b_d),
    .g(g), .e(e), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Digit i of v, counting from the most significant digit.
  function automatic int dig(input int v, input int i);
    return (v >> (DIGIT * (NDIG - 1 - i))) & ((1 << DIGIT) - 1);
  endfunction

  // Monitor: compares each result against the scoreboard, and checks that
  // g/e stay put between done pulses.
  bit held_g = 1'b0;
  bit held_e = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held_g = 1'b0;
      held_e = 1'b0;
    end else if (done) begin
      if (exp_g_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        held_g = exp_g_q.pop_front();
        held_e = exp_e_q.pop_front();
        chk("result_g", g, held_g);
        chk("result_e", e, held_e);
      end
      chk("g_e_exclusive", g & e, 0);
    end else begin
      if (g != held_g || e != held_e) chk("hold_ge", {g, e}, {held_g, held_e});
    end
  end

  // One comparison. stall<0 picks 0..2 idle cycles per digit at random.
  // abort_after>0 pulses rst right after that many transfers.
  task automatic run_op(input int a, input int b, input int stall,
                        input bit hold_start, input int abort_after);
    int  n_exp, n_xfer, s, t;
    bit  fin, decided;
    n_exp = NDIG;
`ifdef EARLY_EXIT_EN
    decided = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (!decided && dig(a, i) != dig(b, i)) begin
        n_exp   = i + 1;
        decided = 1'b1;
      end
`endif
    if (abort_after <= 0) begin
      exp_g_q.push_back(a > b);
      exp_e_q.push_back(a == b);
    end

    // start with a digit already valid: IDLE must not take it.
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    a_d = DIGIT'(dig(a, 0));
    b_d = DIGIT'(dig(b, 0));
    chk("idle_in_ready", in_ready, 0);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    in_valid = 1'b0;
    chk("run_busy", busy, 1);

    n_xfer = 0;
    fin    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!fin) begin
        s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        repeat (s) @(negedge clk);
        a_d = DIGIT'(dig(a, i));
        b_d = DIGIT'(dig(b, i));
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (!in_ready) begin
          chk("in_ready_timeout", 0, 1);
          fin = 1'b1;
        end else begin
          n_xfer++;
          @(negedge clk);
          in_valid = 1'b0;
          if (abort_after > 0 && n_xfer == abort_after) begin
            #2 rst = 1'b1;
            #1;
            chk("abort_outputs", {g, e, done, busy, in_ready}, 0);
            @(negedge clk);
            #1 rst = 1'b0;
            start = 1'b0;
            return;
          end
          if (done) fin = 1'b1;
        end
      end
    end
    // done must sit in the cycle right after the final transfer.
    chk("done_latency", fin, 1);
    chk("digits_taken", n_xfer, n_exp);
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {busy, done, in_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, b;
    #12;
    chk("reset_outputs", {g, e, done, busy, in_ready}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {g, e, done, busy, in_ready}, 0);

    run_op(44, 44, 0, 1'b0, 0);
    run_op(45, 44, 0, 1'b0, 0);
    run_op(0, 63, 0, 1'b0, 0);
    run_op(44, 45, 2, 1'b0, 0);
    run_op(44, 44, 0, 1'b0, 2);        // aborted by reset
    repeat (2) @(negedge clk);
    chk("post_abort_idle", {g, e, done, busy, in_ready}, 0);
    run_op(21, 21, 0, 1'b0, 0);
    run_op(10, 50, 1, 1'b1, 0);        // start held through RUN/DONE
    repeat (3) @(negedge clk);
    chk("no_restart", busy, 0);
    run_op(32, 16, 0, 1'b0, 0);
    run_op(63, 63, 1, 1'b0, 0);
    run_op(1, 0, 0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = (a & ~3) | int'($urandom_range(0, 3));
        default: b = int'($urandom_range(0, 63));
      endcase
      run_op(a, b, -1, 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_g_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
